// File: rtl/lab_tb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lab_tb_pkg : shared types, helpers and truth tables for the lab sweepers
// Revision   : 1.0
// ---------------------------------------------------------------------------
package lab_tb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

    // Lab1: 4-input odd parity, A^B^C^D
    localparam logic [15:0] LAB1_TT = 16'h6996;
    localparam logic [3:0]  AND2_TT = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_hold_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hold_counter : counts 0..HOLD-1 while enabled, last_o flags the final count
// Revision     : 1.0
// ---------------------------------------------------------------------------
module hold_counter #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);
    localparam int            CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// truth_table_sweeper : drives every N-bit vector to a combinational DUT and
//                       checks its output against the EXP truth table
// Revision            : 1.0
// ---------------------------------------------------------------------------
module truth_table_sweeper
    import lab_tb_pkg::*;
#(
    parameter int                       N    = 4,
    parameter int                       HOLD = 4,
    parameter logic [tt_width(N)-1:0]   EXP  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic         dut_f_i,
    output logic [N-1:0] vec_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         pass_o,
    output logic [N:0]   err_count_o,
    output logic         first_err_valid_o,
    output logic [N-1:0] first_err_vec_o
);
    localparam int           EW      = N + 1;
    localparam logic [N-1:0] VEC_MAX = '1;

    sweep_state_t  state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic [N:0]    err_q, err_d;
    logic [N-1:0]  fev_q, fev_d;
    logic          fevv_q, fevv_d;
    logic          hc_clr;
    logic          hc_en;
    logic          hc_last;
    logic          mismatch;

    hold_counter #(
        .HOLD   (HOLD)
    ) u_hold_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (hc_clr),
        .en_i   (hc_en),
        .last_o (hc_last)
    );

    assign mismatch = (dut_f_i != EXP[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fevv_d  = fevv_q;
        hc_clr  = 1'b0;
        hc_en   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // abort outranks start; from IDLE it is simply a no-op
                if (abort_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    fev_d   = '0;
                    fevv_d  = 1'b0;
                    hc_clr  = 1'b1;
                end
            end
            DRIVE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    hc_en = 1'b1;
                    if (hc_last) begin
                        if (mismatch) begin
                            err_d = err_q + EW'(1);
                            if (!fevv_q) begin
                                fev_d  = vec_q;
                                fevv_d = 1'b1;
                            end
                        end
                        if (vec_q == VEC_MAX) begin
                            state_d = DONE;
                        end else begin
                            vec_d = vec_q + N'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fevv_q  <= fevv_d;
        end
    end

    assign vec_o             = vec_q;
    assign busy_o            = (state_q == DRIVE);
    assign done_o            = (state_q == DONE);
    assign pass_o            = (state_q == DONE) && (err_q == '0);
    assign err_count_o       = err_q;
    assign first_err_valid_o = fevv_q;
    assign first_err_vec_o   = fev_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_truth_table_sweeper : randomized self-checking bench, three sweeper configs
// Revision               : 1.0
// ---------------------------------------------------------------------------
module tb_truth_table_sweeper;
    import lab_tb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // A: N=4 HOLD=4 parity table, DUT = parity with injectable faults
    logic        a_start, a_abort, a_f, a_busy, a_done, a_pass, a_fevv;
    logic [3:0]  a_vec, a_fev;
    logic [4:0]  a_err;
    logic [15:0] a_flip;
    // B: N=4 HOLD=4 all-ones table, DUT tied low
    logic        b_start, b_abort, b_busy, b_done, b_pass, b_fevv;
    logic [3:0]  b_vec, b_fev;
    logic [4:0]  b_err;
    // C: N=2 HOLD=1 AND table, DUT = AND with injectable faults
    logic        c_start, c_abort, c_f, c_busy, c_done, c_pass, c_fevv;
    logic [1:0]  c_vec, c_fev;
    logic [2:0]  c_err;
    logic [3:0]  c_flip;

    assign a_f = (^a_vec) ^ a_flip[a_vec];
    assign c_f = (&c_vec) ^ c_flip[c_vec];

    truth_table_sweeper #(.N(4), .HOLD(4), .EXP(LAB1_TT)) u_a (
        .clk(clk), .rst(rst), .start_i(a_start), .abort_i(a_abort), .dut_f_i(a_f),
        .vec_o(a_vec), .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
        .err_count_o(a_err), .first_err_valid_o(a_fevv), .first_err_vec_o(a_fev));

    truth_table_sweeper #(.N(4), .HOLD(4), .EXP(16'hFFFF)) u_b (
        .clk(clk), .rst(rst), .start_i(b_start), .abort_i(b_abort), .dut_f_i(1'b0),
        .vec_o(b_vec), .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
        .err_count_o(b_err), .first_err_valid_o(b_fevv), .first_err_vec_o(b_fev));

    truth_table_sweeper #(.N(2), .HOLD(1), .EXP(AND2_TT)) u_c (
        .clk(clk), .rst(rst), .start_i(c_start), .abort_i(c_abort), .dut_f_i(c_f),
        .vec_o(c_vec), .busy_o(c_busy), .done_o(c_done), .pass_o(c_pass),
        .err_count_o(c_err), .first_err_valid_o(c_fevv), .first_err_vec_o(c_fev));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: mismatches among vectors [0, upto) for a 4-input parity DUT with faults
    function automatic int model_errs_a(input logic [15:0] flip, input int upto);
        int cnt = 0;
        for (int v = 0; v < upto; v++) begin
            if ((($countones(v) % 2) != 0) != (flip[v] ? (($countones(v) % 2) == 0) : (($countones(v) % 2) != 0)))
                cnt++;
        end
        return cnt;
    endfunction

    function automatic int model_first(input logic [15:0] flip, input int nvec);
        for (int v = 0; v < nvec; v++) if (flip[v]) return v;
        return 0;
    endfunction

    task automatic pulse_start_a();
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy/done/pass=%b%b%b required 000", a_busy, a_done, a_pass); end
        checks++; if (a_vec !== 4'd0 || a_err !== 5'd0) begin
            errors++; $display("FAIL reset_vec_err: vec=%0d err=%0d required 0 0", a_vec, a_err); end
        checks++; if (a_fevv !== 1'b0 || a_fev !== 4'd0) begin
            errors++; $display("FAIL reset_first: valid=%b vec=%0d required 0 0", a_fevv, a_fev); end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++; if (a_busy !== 1'b0 || b_busy !== 1'b0 || c_busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy a/b/c=%b%b%b required 000", a_busy, b_busy, c_busy); end
    endtask

    task automatic test_clean_sweep();
        int bad = 0;
        a_flip = 16'h0000;
        pulse_start_a();
        for (int k = 0; k < 64; k++) begin
            if (a_vec !== 4'(k / 4) || a_busy !== 1'b1 || a_done !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL clean_vec_sequence: %0d bad cycles, required 0", bad); end
        checks++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            errors++; $display("FAIL clean_done_at_64: done=%b busy=%b required 1 0", a_done, a_busy); end
        checks++; if (a_err !== 5'd0 || a_pass !== 1'b1 || a_fevv !== 1'b0) begin
            errors++; $display("FAIL clean_result: err=%0d pass=%b fevv=%b required 0 1 0", a_err, a_pass, a_fevv); end
    endtask

    task automatic test_error_sweeps();
        logic [15:0] flips [6];
        flips[0] = 16'h1020;
        flips[1] = 16'h8000;
        for (int i = 2; i < 6; i++) flips[i] = 16'($urandom);
        for (int i = 0; i < 6; i++) begin
            int cyc = 0;
            int exp_e;
            a_flip = flips[i];
            pulse_start_a();
            while (!a_done && cyc < 200) begin @(negedge clk); cyc++; end
            exp_e = model_errs_a(flips[i], 16);
            checks++; if (cyc != 64) begin
                errors++; $display("FAIL err_sweep%0d_latency: done after %0d cycles required 64", i, cyc); end
            checks++; if (a_err !== 5'(exp_e) || a_pass !== (exp_e == 0)) begin
                errors++; $display("FAIL err_sweep%0d_count: err=%0d pass=%b required %0d %b", i, a_err, a_pass, exp_e, exp_e == 0); end
            checks++; if (a_fevv !== (exp_e != 0) || (exp_e != 0 && a_fev !== 4'(model_first(flips[i], 16)))) begin
                errors++; $display("FAIL err_sweep%0d_first: valid=%b vec=%0d required %b %0d", i, a_fevv, a_fev, exp_e != 0, model_first(flips[i], 16)); end
        end
    endtask

    task automatic test_saturate();
        int cyc = 0;
        int exp_e = 0;
        for (int v = 0; v < 16; v++) if (1'b0 != 1'b1) exp_e++;
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        while (!b_done && cyc < 200) begin @(negedge clk); cyc++; end
        checks++; if (b_done !== 1'b1 || b_err !== 5'(exp_e)) begin
            errors++; $display("FAIL all_wrong_count: done=%b err=%0d required 1 %0d", b_done, b_err, exp_e); end
        checks++; if (b_fevv !== 1'b1 || b_fev !== 4'd0 || b_pass !== 1'b0) begin
            errors++; $display("FAIL all_wrong_first: valid=%b vec=%0d pass=%b required 1 0 0", b_fevv, b_fev, b_pass); end
    endtask

    task automatic test_abort();
        int cyc = 0;
        a_flip = 16'hFFFF;
        pulse_start_a();
        while (a_vec !== 4'd7 && cyc < 200) begin @(negedge clk); cyc++; end
        checks++; if (a_vec !== 4'd7) begin
            errors++; $display("FAIL abort_reach_vec7: vec=%0d required 7", a_vec); end
        // abort on the compare cycle of vector 7: that compare must be discarded
        repeat (3) @(negedge clk);
        a_abort = 1'b1;
        @(negedge clk) a_abort = 1'b0;
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_vec !== 4'd7) begin
            errors++; $display("FAIL abort_state: busy=%b done=%b vec=%0d required 0 0 7", a_busy, a_done, a_vec); end
        checks++; if (a_err !== 5'(model_errs_a(16'hFFFF, 7))) begin
            errors++; $display("FAIL abort_discard: err=%0d required %0d", a_err, model_errs_a(16'hFFFF, 7)); end
        a_flip = 16'h0000;
        pulse_start_a();
        checks++; if (a_vec !== 4'd0 || a_err !== 5'd0 || a_busy !== 1'b1) begin
            errors++; $display("FAIL restart_clear: vec=%0d err=%0d busy=%b required 0 0 1", a_vec, a_err, a_busy); end
        cyc = 0;
        while (!a_done && cyc < 200) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 64 || a_pass !== 1'b1) begin
            errors++; $display("FAIL restart_sweep: cycles=%0d pass=%b required 64 1", cyc, a_pass); end
        a_start = 1'b1; a_abort = 1'b1;
        @(negedge clk) begin a_start = 1'b0; a_abort = 1'b0; end
        checks++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL abort_wins_in_done: done=%b busy=%b required 0 0", a_done, a_busy); end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc = 0;
        a_flip = 16'hFFFF;
        pulse_start_a();
        while (a_vec !== 4'd9 && cyc < 200) begin @(negedge clk); cyc++; end
        #2 rst = 1'b1;
        #1;
        checks++; if (a_busy !== 1'b0 || a_vec !== 4'd0 || a_err !== 5'd0 || a_fevv !== 1'b0 || a_fev !== 4'd0) begin
            errors++; $display("FAIL async_reset: busy=%b vec=%0d err=%0d fevv=%b fev=%0d required 0 0 0 0 0", a_busy, a_vec, a_err, a_fevv, a_fev); end
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0 || a_vec !== 4'd0) begin
            errors++; $display("FAIL start_in_reset_ignored: busy=%b done=%b vec=%0d required 0 0 0", a_busy, a_done, a_vec); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int cyc;
        c_flip = 4'h0;
        @(negedge clk) c_start = 1'b1;
        @(negedge clk) c_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (c_vec !== 2'(k) || c_busy !== 1'b1) bad++;
            c_start = (k == 1);
            @(negedge clk);
        end
        c_start = 1'b0;
        checks++; if (bad != 0) begin
            errors++; $display("FAIL hold1_vec_steps: %0d bad cycles required 0", bad); end
        checks++; if (c_done !== 1'b1 || c_pass !== 1'b1 || c_err !== 3'd0) begin
            errors++; $display("FAIL hold1_done_at_4: done=%b pass=%b err=%0d required 1 1 0", c_done, c_pass, c_err); end
        for (int i = 0; i < 4; i++) begin
            int exp_e;
            c_flip = 4'($urandom_range(0, 15));
            exp_e = $countones(c_flip);
            @(negedge clk) c_start = 1'b1;
            @(negedge clk) c_start = 1'b0;
            cyc = 0;
            while (!c_done && cyc < 50) begin @(negedge clk); cyc++; end
            checks++; if (cyc != 4 || c_err !== 3'(exp_e) || c_pass !== (exp_e == 0)) begin
                errors++; $display("FAIL hold1_rand%0d: cycles=%0d err=%0d pass=%b required 4 %0d %b", i, cyc, c_err, c_pass, exp_e, exp_e == 0); end
            checks++; if (c_fevv !== (exp_e != 0) || (exp_e != 0 && c_fev !== 2'(model_first({12'h0, c_flip}, 4)))) begin
                errors++; $display("FAIL hold1_rand%0d_first: valid=%b vec=%0d required %b %0d", i, c_fevv, c_fev, exp_e != 0, model_first({12'h0, c_flip}, 4)); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_flip = 16'h0;
        b_start = 1'b0; b_abort = 1'b0;
        c_start = 1'b0; c_abort = 1'b0; c_flip = 4'h0;
        test_reset();
        test_clean_sweep();
        test_error_sweeps();
        test_saturate();
        test_abort();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised, synthesisable successor to our hand-written exhaustive combinational testbenches. On `start` it drives every input vector from 0 to 2^N−1 onto a combinational DUT. It holds each vector for `HOLD` cycles, then samples the DUT output and compares it against a truth table supplied as a parameter. It reports an error count and the first failing vector, so the same block can check any N-input lab function on the bench or on the board.

## Interface
- `N`, default 4: number of DUT inputs, 1..8.
- `HOLD`, default 4: cycles each vector is held before sampling, ≥1.
- `EXP`, default `16'h0000`, width 2^N: expected truth table; `EXP[v]` is the expected output for vector v.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sweep; sampled only in IDLE or DONE.
- `abort` in 1: synchronous; terminates a sweep in progress.
- `dut_f` in 1: DUT output under test.
- `vec` out N: vector driven to the DUT inputs, MSB = first DUT input (A).
- `busy` out 1: sweep in progress.
- `done` out 1: sweep completed normally; held until next `start`.
- `pass` out 1: `done` and `err_count==0`.
- `err_count` out N+1: number of mismatching vectors, max 2^N, never wraps.
- `first_err_valid` out 1: at least one mismatch this sweep.
- `first_err_vec` out N: vector of the first mismatch.

## Operation
- FSM states:
  - **IDLE**: `busy=0`, `done=0`.
  - **DRIVE**: `busy=1`.
  - **DONE**: `busy=0`, `done=1`.
- Transitions:
  - IDLE→DRIVE on `start`. Clears `vec`, the hold counter, `err_count` and the `first_err_*` outputs.
  - DONE→DRIVE on `start`, with the same clears as IDLE→DRIVE.
  - DONE→IDLE on `abort`; `done` drops.
- DRIVE behaviour:
  - Hold counter `hc` runs 0..HOLD−1.
  - At `hc==HOLD−1`, sample `dut_f` and compare it with `EXP[vec]`.
  - On mismatch, `err_count` increments. If `first_err_valid==0`, capture `vec` into `first_err_vec` and set `first_err_valid`.
  - If `vec==2^N−1`, go to DONE. Otherwise `vec` increments and `hc` returns to 0.
- `abort` in DRIVE goes to IDLE. `vec` and the counters keep their last values, `done` stays 0, and the compare in that cycle is discarded.
- `start` while in DRIVE is ignored.
- If `start` and `abort` are high in the same cycle, `abort` wins.
- `vec` is driven from a register and only changes on hold-counter wrap, so the DUT sees glitch-free inputs.

## Timing
- Reset values (asynchronous):
  - State = IDLE.
  - `vec=0`, `hc=0`, `err_count=0`, `first_err_vec=0`.
  - `busy=0`, `done=0`, `pass=0`, `first_err_valid=0`.
- Cycle after `start` is seen: `busy=1`, `vec=0`.
- Each vector is present for exactly HOLD cycles.
- Sampling happens on the rising edge that ends the HOLD-th cycle. DUT combinational delay plus routing must be less than HOLD clock periods.
- `done` rises 2^N·HOLD cycles after the first `busy` cycle. `err_count` is final in that same cycle.
- `rst` asserted mid-sweep forces all reset values immediately, with no pending compare. After release, the block waits in IDLE for `start`.
- With HOLD=1, `vec` changes every cycle and every cycle is a compare cycle.

## Structure
- Shared package `lab_tb_pkg`:
  - FSM state enum: IDLE, DRIVE, DONE.
  - Function `tt_width(N)=1<<N`.
  - Common truth-table constants, e.g. the Lab1 function.
- One sub-module, `hold_counter`. It is parametrised by HOLD, with inputs `clk`, `rst`, `clr`, `en` and output `last` (pulses at HOLD−1). The FSM, vector register and error tracking stay in the top module.

## Test plan
- N=4, HOLD=4, `EXP` equal to the DUT function, correct DUT. Pulse `start`:
  - `vec` visits 0..15, each for 4 cycles.
  - `done` rises at cycle 64.
  - `err_count=0`, `pass=1`, `first_err_valid=0`.
- Same setup, but the DUT output is inverted for vectors 5 and 12:
  - `err_count=2`, `first_err_vec=4'd5`, `first_err_valid=1`, `pass=0`.
- DUT tied to 0 with `EXP=16'hFFFF`:
  - `err_count=16` (5'b10000); the counter does not wrap.
  - `first_err_vec=0`.
- Abort path:
  - Assert `abort` when `vec=7` → next cycle IDLE, `busy=0`, `done=0`, `vec=7`.
  - Then pulse `start` → `vec=0`, `err_count=0`, and a full sweep completes.
- Reset mid-sweep:
  - Assert `rst` asynchronously when `vec=9` (not on a clock edge) → all outputs go to reset values before the next edge.
  - A `start` pulse during reset is ignored.
- N=2, HOLD=1, `EXP=4'b1000` (AND), DUT = AND:
  - `vec` steps 0,1,2,3 on consecutive cycles.
  - `done` rises at cycle 4, `pass=1`.
  - A `start` pulse issued while `busy` has no effect.
